// File: rtl/gyro_display_pkg.sv
// Shared definitions for the gyro display path: channel select encodings,
// the sequencer FSM state type and a channel-step helper.
package gyro_display_pkg;

    localparam int unsigned SEL_W = 2;

    typedef logic [SEL_W-1:0] sel_t;

    // Channel select encodings seen by the seven-segment controller
    localparam sel_t SEL_X    = 2'b00;
    localparam sel_t SEL_Y    = 2'b01;
    localparam sel_t SEL_Z    = 2'b10;
    localparam sel_t SEL_TEMP = 2'b11;

    typedef enum logic [1:0] {
        ST_MANUAL     = 2'd0,
        ST_AUTO_DWELL = 2'd1,
        ST_AUTO_WAIT  = 2'd2
    } seq_state_t;

    // Next channel in rotation; SEL_TEMP wraps back to SEL_X
    function automatic sel_t next_sel(input sel_t cur);
        return cur + sel_t'(1);
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Conditions one raw pushbutton: 2-flop synchronizer, stable-count debouncer
// and a one-cycle press pulse on the debounced rising edge.
//   clk, rst : clock, async active-high reset
//   btn      : raw asynchronous button level
//   press    : registered one-cycle pulse per accepted press
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             level;
    logic             level_q;
    logic [CNT_W-1:0] stable_cnt;

    // Synchronizer, debounce counter and rising-edge pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q     <= 2'b00;
            level      <= 1'b0;
            level_q    <= 1'b0;
            stable_cnt <= '0;
            press      <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn};
            // Count cycles the synced level disagrees with the accepted one;
            // any agreement (a bounce back) restarts the count.
            if (sync_q[1] == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_LAST) begin
                level      <= sync_q[1];
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + CNT_W'(1);
            end
            level_q <= level;
            press   <= level & ~level_q;
        end
    end

endmodule

// File: rtl/display_sequencer.sv
// Chooses which gyro channel (X/Y/Z/temperature) the display shows and in
// which number format. Auto mode rotates channels after a dwell period, on
// the next fresh sample; manual mode steps on a debounced button press.
//   clk, rst    : clock, async active-high reset
//   btn_next    : raw button, step to next channel
//   btn_mode    : raw button, toggle auto/manual
//   dec_sw      : raw switch, decimal format request
//   data_valid  : one-cycle pulse per new gyro sample set
//   sel         : channel select (00 X, 01 Y, 10 Z, 11 temperature)
//   display_sel : synchronized dec_sw
//   auto_mode   : high while in an auto state
//   chan_change : one-cycle pulse in the first cycle of a new sel
module display_sequencer #(
    parameter int unsigned DWELL_CYCLES    = 200_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_next,
    input  logic       btn_mode,
    input  logic       dec_sw,
    input  logic       data_valid,
    output logic [1:0] sel,
    output logic       display_sel,
    output logic       auto_mode,
    output logic       chan_change
);

    import gyro_display_pkg::*;

    localparam int unsigned DWELL_W = $clog2(DWELL_CYCLES);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

    seq_state_t         state;
    seq_state_t         state_next;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [DWELL_W-1:0] dwell_next;
    sel_t               sel_next;
    logic               change_next;
    logic               next_press;
    logic               mode_press;
    logic [1:0]         dec_sync;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_next_db (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn_next),
        .press(next_press)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_mode_db (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn_mode),
        .press(mode_press)
    );

    // Format switch: synchronized only, not debounced
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_sync    <= 2'b00;
            display_sel <= 1'b0;
        end else begin
            dec_sync    <= {dec_sync[0], dec_sw};
            display_sel <= dec_sync[1];
        end
    end

    // State, dwell counter and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_AUTO_DWELL;
            dwell_cnt   <= '0;
            sel         <= SEL_X;
            chan_change <= 1'b0;
            auto_mode   <= 1'b1;
        end else begin
            state       <= state_next;
            dwell_cnt   <= dwell_next;
            sel         <= sel_next;
            chan_change <= change_next;
            auto_mode   <= (state_next != ST_MANUAL);
        end
    end

    // Next-state logic; a mode press always beats a same-cycle next press,
    // and next press plus data_valid in AUTO_WAIT yields a single step.
    always_comb begin
        state_next  = state;
        dwell_next  = dwell_cnt;
        sel_next    = sel;
        change_next = 1'b0;
        case (state)
            ST_MANUAL: begin
                if (mode_press) begin
                    state_next = ST_AUTO_DWELL;
                    dwell_next = '0;
                end else if (next_press) begin
                    sel_next    = next_sel(sel);
                    change_next = 1'b1;
                end
            end
            ST_AUTO_DWELL: begin
                if (mode_press) begin
                    state_next = ST_MANUAL;
                end else if (next_press) begin
                    sel_next    = next_sel(sel);
                    change_next = 1'b1;
                    dwell_next  = '0;
                end else if (dwell_cnt == DWELL_LAST) begin
                    state_next = ST_AUTO_WAIT;
                end else begin
                    dwell_next = dwell_cnt + DWELL_W'(1);
                end
            end
            ST_AUTO_WAIT: begin
                if (mode_press) begin
                    state_next = ST_MANUAL;
                end else if (next_press || data_valid) begin
                    state_next  = ST_AUTO_DWELL;
                    sel_next    = next_sel(sel);
                    change_next = 1'b1;
                    dwell_next  = '0;
                end
            end
            default: begin
                state_next = ST_AUTO_DWELL;
                dwell_next = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_display_sequencer.sv
// Self-checking bench for display_sequencer with short dwell/debounce
// settings. Expected channel values go into a queue when stimulus is
// applied and are matched against every chan_change pulse.
module tb_display_sequencer;

    localparam int unsigned DWELL    = 8;
    localparam int unsigned DEBOUNCE = 4;

    logic       clk;
    logic       rst;
    logic       btn_next;
    logic       btn_mode;
    logic       dec_sw;
    logic       data_valid;
    logic [1:0] sel;
    logic       display_sel;
    logic       auto_mode;
    logic       chan_change;

    logic       dv_auto;
    logic       dv_man;
    logic       dv_en;
    logic       chk_dv;
    logic       dv_d;
    int         cyc;
    int         last_chg;
    int         chg_cnt;
    int         exp_chg;
    int         n_tests;
    int         n_fail;
    logic [1:0] exp_q[$];

    assign data_valid = dv_auto | dv_man;

    display_sequencer #(
        .DWELL_CYCLES   (DWELL),
        .DEBOUNCE_CYCLES(DEBOUNCE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_next   (btn_next),
        .btn_mode   (btn_mode),
        .dec_sw     (dec_sw),
        .data_valid (data_valid),
        .sel        (sel),
        .display_sel(display_sel),
        .auto_mode  (auto_mode),
        .chan_change(chan_change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_sel(input logic [1:0] v);
        exp_q.push_back(v);
        exp_chg++;
    endtask

    task automatic press_next();
        btn_next = 1'b1;
        tick(DEBOUNCE + 6);
        btn_next = 1'b0;
        tick(DEBOUNCE + 6);
    endtask

    task automatic press_mode();
        btn_mode = 1'b1;
        tick(DEBOUNCE + 6);
        btn_mode = 1'b0;
        tick(DEBOUNCE + 6);
    endtask

    // Cycle counter and data_valid as sampled by the DUT
    initial begin : edge_track
        cyc  = 0;
        dv_d = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            dv_d = data_valid;
        end
    end

    // Periodic sample generator: one pulse every 3 cycles while enabled
    initial begin : dv_gen
        int k;
        k       = 0;
        dv_auto = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            dv_auto = dv_en && (k == 0);
            k = (k == 2) ? 0 : k + 1;
        end
    end

    // Scoreboard: every chan_change must match the oldest expected channel
    initial begin : monitor
        logic [1:0] exp_sel;
        last_chg = 0;
        chg_cnt  = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_chg = cyc;
            end else if (chan_change) begin
                chg_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_chg", 32'(sel), 32'hFFFF_FFFF);
                end else begin
                    exp_sel = exp_q.pop_front();
                    check("sel_on_chg", 32'(sel), 32'(exp_sel));
                end
                if (chk_dv) begin
                    check("dv_before_chg", 32'(dv_d), 32'd1);
                    check("interval_ge9", 32'((cyc - last_chg) >= 9), 32'd1);
                end
                last_chg = cyc;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        n_tests  = 0;
        n_fail   = 0;
        exp_chg  = 0;
        rst      = 1'b1;
        btn_next = 1'b0;
        btn_mode = 1'b0;
        dec_sw   = 1'b0;
        dv_man   = 1'b0;
        dv_en    = 1'b0;
        chk_dv   = 1'b0;
        tick(3);

        // Reset state
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_auto", 32'(auto_mode), 32'd1);
        check("rst_chg", 32'(chan_change), 32'd0);
        check("rst_disp", 32'(display_sel), 32'd0);
        rst = 1'b0;

        // Auto rotation through all four channels, with wrap
        expect_sel(2'd1);
        expect_sel(2'd2);
        expect_sel(2'd3);
        expect_sel(2'd0);
        chk_dv = 1'b1;
        dv_en  = 1'b1;
        for (int i = 0; i < 150 && chg_cnt < 4; i++) tick(1);
        dv_en  = 1'b0;
        chk_dv = 1'b0;
        check("auto_rot_count", 32'(chg_cnt), 32'd4);

        // Mode press: auto_mode drops exactly DEBOUNCE+4 cycles later
        btn_mode = 1'b1;
        tick(DEBOUNCE + 3);
        check("mode_lat_before", 32'(auto_mode), 32'd1);
        tick(1);
        check("mode_lat_at", 32'(auto_mode), 32'd0);
        check("mode_sel_hold", 32'(sel), 32'd0);
        btn_mode = 1'b0;
        tick(DEBOUNCE + 6);

        // Manual stepping with data_valid running (must be ignored)
        dv_en = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            expect_sel(2'(i));
            press_next();
        end
        tick(12);
        dv_en = 1'b0;
        check("manual_sel", 32'(sel), 32'd3);
        check("manual_mode", 32'(auto_mode), 32'd0);

        // Bouncing next button, then stable: one step, 8 cycles after settle
        expect_sel(2'd0);
        for (int i = 0; i < 5; i++) begin
            btn_next = 1'b1;
            tick(2);
            btn_next = 1'b0;
            tick(2);
        end
        btn_next = 1'b1;
        tick(DEBOUNCE + 3);
        check("bounce_before", 32'(sel), 32'd3);
        tick(1);
        check("bounce_at", 32'(sel), 32'd0);
        btn_next = 1'b0;
        tick(DEBOUNCE + 6);

        // Back to auto, then simultaneous mode + next: mode wins
        press_mode();
        check("back_auto", 32'(auto_mode), 32'd1);
        btn_mode = 1'b1;
        btn_next = 1'b1;
        tick(DEBOUNCE + 6);
        check("simul_mode", 32'(auto_mode), 32'd0);
        check("simul_sel", 32'(sel), 32'd0);
        btn_mode = 1'b0;
        btn_next = 1'b0;
        tick(DEBOUNCE + 6);

        // AUTO_WAIT: next press pulse and data_valid in the same cycle
        press_mode();
        tick(DWELL + 4);
        expect_sel(2'd1);
        btn_next = 1'b1;
        tick(DEBOUNCE + 3);
        dv_man = 1'b1;
        tick(1);
        dv_man = 1'b0;
        tick(5);
        check("wait_both_sel", 32'(sel), 32'd1);
        check("wait_both_cnt", 32'(chg_cnt), 32'(exp_chg));
        btn_next = 1'b0;
        tick(DEBOUNCE + 6);

        // display_sel latency
        dec_sw = 1'b1;
        tick(2);
        check("disp_lat_before", 32'(display_sel), 32'd0);
        tick(1);
        check("disp_lat_at", 32'(display_sel), 32'd1);

        // Async reset mid-dwell and mid-debounce
        expect_sel(2'd2);
        dv_man = 1'b1;
        tick(1);
        dv_man = 1'b0;
        tick(3);
        btn_next = 1'b1;
        tick(4);
        #2;
        rst = 1'b1;
        #1;
        check("arst_sel", 32'(sel), 32'd0);
        check("arst_auto", 32'(auto_mode), 32'd1);
        check("arst_disp", 32'(display_sel), 32'd0);
        check("arst_chg", 32'(chan_change), 32'd0);
        btn_next = 1'b0;
        tick(2);
        rst = 1'b0;
        expect_sel(2'd1);
        dv_man = 1'b1;
        tick(3);
        check("post_rst_disp", 32'(display_sel), 32'd1);
        tick(DWELL - 3);
        check("post_rst_dwell", 32'(sel), 32'd0);
        tick(1);
        check("post_rst_adv", 32'(sel), 32'd1);
        dv_man = 1'b0;
        tick(4);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        check("chg_total", 32'(chg_cnt), 32'(exp_chg));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
